rv_decode_stage: RTL and testbench

- Registered, parametrised RV32I/RV64I base-ISA instruction-decode pipeline stage with valid/ready handshakes on both sides.
- Sits between fetch and register-read/execute. Splits the instruction into fields, produces a sign-extended immediate of XLEN bits, a one-hot format code and an illegal-instruction flag.
- Optional skid buffer (registered in_ready); saturating decode/illegal performance counters.

---
 rtl/rv_decode_stage.sv | 196 +++++++++++++++++++
 tb/tb_rv_decode_stage.sv | 499 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_decode_stage.sv
// ============================================================================
// Module   : rv_decode_stage
// Brief    : Registered RV32I/RV64I decode stage with valid/ready handshakes,
//            optional skid buffer and saturating performance counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_decode_stage #(
    parameter int XLEN    = 32,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [6:0]       out_opcode,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [XLEN-1:0]  out_imm,
    output logic [5:0]       out_fmt,
    output logic             out_illegal,
    output logic [CNT_W-1:0] dec_count,
    output logic [CNT_W-1:0] ill_count
);

    localparam logic [6:0] c_OP_R     = 7'b0110011;
    localparam logic [6:0] c_OP_IMM   = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_JALR  = 7'b1100111;
    localparam logic [6:0] c_OP_SYS   = 7'b1110011;
    localparam logic [6:0] c_OP_FENCE = 7'b0001111;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC = 7'b0010111;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic [5:0]      fmt;
        logic            illegal;
    } bundle_t;

    bundle_t          w_dec;
    logic [5:0]       w_fmt;
    logic [31:0]      w_imm32;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_out_free;

    bundle_t          r_out;
    bundle_t          r_skid;
    logic             r_out_valid;
    logic             r_skid_valid;
    logic [CNT_W-1:0] r_dec_count;
    logic [CNT_W-1:0] r_ill_count;

    // Format one-hot is {J,U,B,S,I,R}; zero means illegal.
    always_comb begin
        w_fmt = 6'b000000;
        if (in_instr[1:0] == 2'b11) begin
            case (in_instr[6:0])
                c_OP_R:                                   w_fmt = 6'b000001;
                c_OP_IMM, c_OP_LOAD, c_OP_JALR,
                c_OP_SYS, c_OP_FENCE:                     w_fmt = 6'b000010;
                c_OP_STORE:                               w_fmt = 6'b000100;
                c_OP_BR:                                  w_fmt = 6'b001000;
                c_OP_LUI, c_OP_AUIPC:                     w_fmt = 6'b010000;
                c_OP_JAL:                                 w_fmt = 6'b100000;
                default:                                  w_fmt = 6'b000000;
            endcase
        end
    end

    always_comb begin
        w_imm32 = 32'd0;
        if (w_fmt[1])
            w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        else if (w_fmt[2])
            w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        else if (w_fmt[3])
            w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                       in_instr[30:25], in_instr[11:8], 1'b0};
        else if (w_fmt[4])
            w_imm32 = {in_instr[31:12], 12'd0};
        else if (w_fmt[5])
            w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                       in_instr[20], in_instr[30:21], 1'b0};
    end

    always_comb begin
        w_dec         = '0;
        w_dec.pc      = in_pc;
        w_dec.fmt     = w_fmt;
        w_dec.illegal = (w_fmt == 6'b000000);
        w_dec.imm     = XLEN'($signed(w_imm32));
        w_dec.opcode  = w_dec.illegal ? 7'd0 : in_instr[6:0];
        w_dec.rd      = (w_fmt[0] | w_fmt[1] | w_fmt[4] | w_fmt[5]) ? in_instr[11:7]  : 5'd0;
        w_dec.rs1     = (w_fmt[0] | w_fmt[1] | w_fmt[2] | w_fmt[3]) ? in_instr[19:15] : 5'd0;
        w_dec.rs2     = (w_fmt[0] | w_fmt[2] | w_fmt[3])            ? in_instr[24:20] : 5'd0;
        w_dec.funct3  = (w_fmt[0] | w_fmt[1] | w_fmt[2] | w_fmt[3]) ? in_instr[14:12] : 3'd0;
        w_dec.funct7  = w_fmt[0] ? in_instr[31:25] : 7'd0;
    end

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = r_out_valid & out_ready;
    assign w_out_free = ~r_out_valid | out_ready;

    // A pending skid entry always drains into the output before new input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                r_out       <= r_skid;
                r_out_valid <= 1'b1;
            end else if (w_in_fire) begin
                r_out       <= w_dec;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    generate
        if (SKID_EN != 0) begin : g_skid
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_skid_valid <= 1'b0;
                    r_skid       <= '0;
                end else if (flush || w_out_free) begin
                    r_skid_valid <= 1'b0;
                end else if (w_in_fire) begin
                    r_skid       <= w_dec;
                    r_skid_valid <= 1'b1;
                end
            end
            assign in_ready = rst_n & ~r_skid_valid;
        end else begin : g_no_skid
            assign r_skid_valid = 1'b0;
            assign r_skid       = '0;
            assign in_ready     = rst_n & w_out_free;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dec_count <= '0;
            r_ill_count <= '0;
        end else if (!flush && w_out_fire) begin
            if (r_dec_count != {CNT_W{1'b1}})
                r_dec_count <= r_dec_count + CNT_W'(1);
            if (r_out.illegal && (r_ill_count != {CNT_W{1'b1}}))
                r_ill_count <= r_ill_count + CNT_W'(1);
        end
    end

    assign out_valid   = r_out_valid;
    assign out_pc      = r_out.pc;
    assign out_opcode  = r_out.opcode;
    assign out_rd      = r_out.rd;
    assign out_rs1     = r_out.rs1;
    assign out_rs2     = r_out.rs2;
    assign out_funct3  = r_out.funct3;
    assign out_funct7  = r_out.funct7;
    assign out_imm     = r_out.imm;
    assign out_fmt     = r_out.fmt;
    assign out_illegal = r_out.illegal;
    assign dec_count   = r_dec_count;
    assign ill_count   = r_ill_count;

endmodule

`default_nettype wire

// File: tb/tb_rv_decode_stage.sv
// ============================================================================
// Module   : tb_rv_decode_stage
// Brief    : Scoreboard bench for rv_decode_stage (32-bit skid and 64-bit no-skid).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_decode_stage;

    typedef struct packed {
        logic [63:0] pc;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm;
        logic [5:0]  fmt;
        logic        ill;
    } exp_t;

    logic clk;
    logic rst_n;

    logic        flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_illegal_a;
    logic [31:0] in_instr_a, in_pc_a, out_pc_a, out_imm_a;
    logic [6:0]  out_opcode_a, out_funct7_a;
    logic [4:0]  out_rd_a, out_rs1_a, out_rs2_a;
    logic [2:0]  out_funct3_a;
    logic [5:0]  out_fmt_a;
    logic [3:0]  dec_a, ill_a;

    logic        flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_illegal_b;
    logic [31:0] in_instr_b;
    logic [63:0] in_pc_b, out_pc_b, out_imm_b;
    logic [6:0]  out_opcode_b, out_funct7_b;
    logic [4:0]  out_rd_b, out_rs1_b, out_rs2_b;
    logic [2:0]  out_funct3_b;
    logic [5:0]  out_fmt_b;
    logic [15:0] dec_b, ill_b;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    int   popped_a = 0, popped_b = 0;
    int   exp_dec_a = 0, exp_ill_a = 0, exp_dec_b = 0, exp_ill_b = 0;
    logic stream_done;

    rv_decode_stage #(.XLEN(32), .SKID_EN(1), .CNT_W(4)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(flush_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_instr(in_instr_a), .in_pc(in_pc_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_pc(out_pc_a),
        .out_opcode(out_opcode_a), .out_rd(out_rd_a), .out_rs1(out_rs1_a), .out_rs2(out_rs2_a),
        .out_funct3(out_funct3_a), .out_funct7(out_funct7_a), .out_imm(out_imm_a),
        .out_fmt(out_fmt_a), .out_illegal(out_illegal_a), .dec_count(dec_a), .ill_count(ill_a)
    );

    rv_decode_stage #(.XLEN(64), .SKID_EN(0), .CNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(flush_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_instr(in_instr_b), .in_pc(in_pc_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_pc(out_pc_b),
        .out_opcode(out_opcode_b), .out_rd(out_rd_b), .out_rs1(out_rs1_b), .out_rs2(out_rs2_b),
        .out_funct3(out_funct3_b), .out_funct7(out_funct7_b), .out_imm(out_imm_b),
        .out_fmt(out_fmt_b), .out_illegal(out_illegal_b), .dec_count(dec_b), .ill_count(ill_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference decoder producing 64-bit results; the 32-bit DUT is compared on the low half.
    function automatic exp_t model(input logic [31:0] i, input logic [63:0] pc);
        exp_t e;
        e    = '0;
        e.pc = pc;
        if (i[1:0] == 2'b11) begin
            case (i[6:0])
                7'h33: begin
                    e.fmt = 6'b000001; e.rd = i[11:7]; e.rs1 = i[19:15];
                    e.rs2 = i[24:20]; e.f3 = i[14:12]; e.f7 = i[31:25];
                end
                7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: begin
                    e.fmt = 6'b000010; e.rd = i[11:7]; e.rs1 = i[19:15]; e.f3 = i[14:12];
                    e.imm = {{52{i[31]}}, i[31:20]};
                end
                7'h23: begin
                    e.fmt = 6'b000100; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.f3 = i[14:12];
                    e.imm = {{52{i[31]}}, i[31:25], i[11:7]};
                end
                7'h63: begin
                    e.fmt = 6'b001000; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.f3 = i[14:12];
                    e.imm = {{52{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
                end
                7'h37, 7'h17: begin
                    e.fmt = 6'b010000; e.rd = i[11:7];
                    e.imm = {{32{i[31]}}, i[31:12], 12'h000};
                end
                7'h6F: begin
                    e.fmt = 6'b100000; e.rd = i[11:7];
                    e.imm = {{44{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
                end
                default: ;
            endcase
        end
        e.ill = (e.fmt == 6'b000000);
        if (!e.ill) e.opc = i[6:0];
        return e;
    endfunction

    always @(negedge clk) begin : mon_a
        exp_t ea;
        logic [102:0] got_a, want_a;
        if (!rst_n || flush_a) begin
            q_a.delete();
            if (!rst_n) begin exp_dec_a = 0; exp_ill_a = 0; end
        end else begin
            if (out_valid_a && out_ready_a) begin
                n_checks++;
                if (q_a.size() == 0) begin
                    n_fail++;
                    $display("FAIL mon_a_unexpected: got bundle pc=%h, required no bundle", out_pc_a);
                end else begin
                    ea = q_a.pop_front();
                    popped_a++;
                    got_a  = {out_pc_a, out_opcode_a, out_rd_a, out_rs1_a, out_rs2_a, out_funct3_a,
                              out_funct7_a, out_imm_a, out_fmt_a, out_illegal_a};
                    want_a = {ea.pc[31:0], ea.opc, ea.rd, ea.rs1, ea.rs2, ea.f3, ea.f7,
                              ea.imm[31:0], ea.fmt, ea.ill};
                    if (got_a !== want_a) begin
                        n_fail++;
                        $display("FAIL mon_a_bundle: got %h, required %h", got_a, want_a);
                    end
                    if (exp_dec_a < 15) exp_dec_a++;
                    if (ea.ill && exp_ill_a < 15) exp_ill_a++;
                end
            end
            if (in_valid_a && in_ready_a) q_a.push_back(model(in_instr_a, {32'h0, in_pc_a}));
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t eb;
        logic [166:0] got_b, want_b;
        if (!rst_n || flush_b) begin
            q_b.delete();
            if (!rst_n) begin exp_dec_b = 0; exp_ill_b = 0; end
        end else begin
            if (out_valid_b && out_ready_b) begin
                n_checks++;
                if (q_b.size() == 0) begin
                    n_fail++;
                    $display("FAIL mon_b_unexpected: got bundle pc=%h, required no bundle", out_pc_b);
                end else begin
                    eb = q_b.pop_front();
                    popped_b++;
                    got_b  = {out_pc_b, out_opcode_b, out_rd_b, out_rs1_b, out_rs2_b, out_funct3_b,
                              out_funct7_b, out_imm_b, out_fmt_b, out_illegal_b};
                    want_b = {eb.pc, eb.opc, eb.rd, eb.rs1, eb.rs2, eb.f3, eb.f7,
                              eb.imm, eb.fmt, eb.ill};
                    if (got_b !== want_b) begin
                        n_fail++;
                        $display("FAIL mon_b_bundle: got %h, required %h", got_b, want_b);
                    end
                    if (exp_dec_b < 65535) exp_dec_b++;
                    if (eb.ill && exp_ill_b < 65535) exp_ill_b++;
                end
            end
            if (in_valid_b && in_ready_b) q_b.push_back(model(in_instr_b, in_pc_b));
        end
    end

    task automatic push_a(input logic [31:0] ins, input logic [31:0] pc);
        int t = 0;
        in_valid_a = 1'b1; in_instr_a = ins; in_pc_a = pc;
        @(negedge clk);
        while (!in_ready_a && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) begin
            n_checks++; n_fail++;
            $display("FAIL push_a_timeout: in_ready stayed 0 for %0d cycles, required 1", t);
        end
        @(posedge clk); #1;
        in_valid_a = 1'b0;
    endtask

    task automatic push_b(input logic [31:0] ins, input logic [63:0] pc);
        int t = 0;
        in_valid_b = 1'b1; in_instr_b = ins; in_pc_b = pc;
        @(negedge clk);
        while (!in_ready_b && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) begin
            n_checks++; n_fail++;
            $display("FAIL push_b_timeout: in_ready stayed 0 for %0d cycles, required 1", t);
        end
        @(posedge clk); #1;
        in_valid_b = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid_a, in_ready_a, dec_a, ill_a} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl_a: got %b, required 0", {out_valid_a, in_ready_a, dec_a, ill_a});
        end
        n_checks++;
        if ({out_pc_a, out_opcode_a, out_rd_a, out_imm_a, out_fmt_a, out_illegal_a} !== '0) begin
            n_fail++;
            $display("FAIL reset_data_a: got pc=%h imm=%h fmt=%b, required 0", out_pc_a, out_imm_a, out_fmt_a);
        end
        n_checks++;
        if ({out_valid_b, in_ready_b, dec_b, ill_b, out_pc_b, out_imm_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_b: got valid=%b ready=%b dec=%0d pc=%h, required 0", out_valid_b, in_ready_b, dec_b, out_pc_b);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({in_ready_a, in_ready_b} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b, required 11", {in_ready_a, in_ready_b});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
        out_ready_a = 1'b1;
        push_a(32'h0000_0000, 32'h0000_0040);
        n_checks++;
        if ({out_valid_a, out_illegal_a, out_fmt_a, out_imm_a, out_pc_a} !== {1'b1, 1'b1, 6'd0, 32'd0, 32'h40}) begin
            n_fail++;
            $display("FAIL illegal_zero: got v=%b ill=%b fmt=%b imm=%h pc=%h, required 1 1 0 0 40",
                     out_valid_a, out_illegal_a, out_fmt_a, out_imm_a, out_pc_a);
        end
        push_a(32'h0000_007F, 32'h0000_0044);
        n_checks++;
        if ({out_illegal_a, out_fmt_a, out_imm_a, out_opcode_a} !== {1'b1, 6'd0, 32'd0, 7'd0}) begin
            n_fail++;
            $display("FAIL illegal_7f: got ill=%b fmt=%b imm=%h opc=%h, required 1 0 0 0",
                     out_illegal_a, out_fmt_a, out_imm_a, out_opcode_a);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({dec_a, ill_a} !== {4'd2, 4'd2}) begin
            n_fail++;
            $display("FAIL illegal_counts: got dec=%0d ill=%0d, required 2 2", dec_a, ill_a);
        end
    endtask

    task automatic test_decode32();
        push_a(32'hFFF0_0093, 32'h0000_0100);
        n_checks++;
        if ({out_valid_a, out_fmt_a, out_rd_a, out_rs1_a, out_imm_a} !== {1'b1, 6'b000010, 5'd1, 5'd0, 32'hFFFF_FFFF}) begin
            n_fail++;
            $display("FAIL decode32_addi: got v=%b fmt=%b rd=%0d rs1=%0d imm=%h, required 1 000010 1 0 ffffffff",
                     out_valid_a, out_fmt_a, out_rd_a, out_rs1_a, out_imm_a);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL decode32_drain: got out_valid=%b, required 0", out_valid_a);
        end
    endtask

    task automatic test_decode64();
        out_ready_b = 1'b1;
        push_b(32'hFE00_0EE3, 64'h8000_0000_0000_1000);
        n_checks++;
        if ({out_fmt_b, out_imm_b} !== {6'b001000, 64'hFFFF_FFFF_FFFF_FFFC}) begin
            n_fail++;
            $display("FAIL decode64_beq: got fmt=%b imm=%h, required 001000 fffffffffffffffc", out_fmt_b, out_imm_b);
        end
        push_b(32'h0080_00EF, 64'h8000_0000_0000_1004);
        n_checks++;
        if ({out_fmt_b, out_rd_b, out_imm_b} !== {6'b100000, 5'd1, 64'd8}) begin
            n_fail++;
            $display("FAIL decode64_jal: got fmt=%b rd=%0d imm=%h, required 100000 1 8", out_fmt_b, out_rd_b, out_imm_b);
        end
        push_b(32'h8000_00B7, 64'h8000_0000_0000_1008);
        n_checks++;
        if ({out_fmt_b, out_rd_b, out_imm_b} !== {6'b010000, 5'd1, 64'hFFFF_FFFF_8000_0000}) begin
            n_fail++;
            $display("FAIL decode64_lui: got fmt=%b rd=%0d imm=%h, required 010000 1 ffffffff80000000", out_fmt_b, out_rd_b, out_imm_b);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back_skid();
        int p0;
        p0 = popped_a;
        out_ready_a = 1'b0;
        fork
            begin
                push_a(32'h0020_81B3, 32'h200);
                push_a(32'h0011_2223, 32'h204);
                push_a(32'h1234_5037, 32'h208);
                push_a(32'hFE00_0EE3, 32'h20C);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                n_checks++;
                if ({in_ready_a, out_valid_a, out_pc_a} !== {1'b0, 1'b1, 32'h200}) begin
                    n_fail++;
                    $display("FAIL skid_stall: got ready=%b valid=%b pc=%h, required 0 1 200", in_ready_a, out_valid_a, out_pc_a);
                end
                out_ready_a = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (popped_a - p0 !== 4 || q_a.size() !== 0) begin
            n_fail++;
            $display("FAIL skid_drain: got %0d emerged (%0d pending), required 4 (0)", popped_a - p0, q_a.size());
        end
    endtask

    task automatic test_back_to_back_noskid();
        int p0;
        out_ready_b = 1'b0;
        push_b(32'h0010_0113, 64'h300);
        n_checks++;
        if (in_ready_b !== 1'b0) begin
            n_fail++;
            $display("FAIL noskid_stalled: got in_ready=%b, required 0", in_ready_b);
        end
        out_ready_b = 1'b1;
        #1;
        n_checks++;
        if (in_ready_b !== 1'b1) begin
            n_fail++;
            $display("FAIL noskid_comb_rise: got in_ready=%b, required 1", in_ready_b);
        end
        out_ready_b = 1'b0;
        #1;
        n_checks++;
        if (in_ready_b !== 1'b0) begin
            n_fail++;
            $display("FAIL noskid_comb_fall: got in_ready=%b, required 0", in_ready_b);
        end
        out_ready_b = 1'b1;
        @(posedge clk); #1;
        p0 = popped_b;
        stream_done = 1'b0;
        fork
            begin
                push_b(32'h0020_81B3, 64'h310);
                push_b(32'h0000_007F, 64'h314);
                push_b(32'hFE00_0EE3, 64'h318);
                push_b(32'h0080_00EF, 64'h31C);
                stream_done = 1'b1;
            end
            begin
                for (int k = 0; k < 200 && !stream_done; k++) begin
                    @(posedge clk); #1;
                    out_ready_b = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (popped_b - p0 !== 4 || q_b.size() !== 0) begin
            n_fail++;
            $display("FAIL noskid_drain: got %0d emerged (%0d pending), required 4 (0)", popped_b - p0, q_b.size());
        end
    endtask

    task automatic test_flush();
        logic [3:0] d0, i0;
        int p0;
        out_ready_a = 1'b0;
        push_a(32'h0050_0293, 32'h400);
        push_a(32'h0000_0000, 32'h404);
        n_checks++;
        if ({in_ready_a, out_valid_a} !== 2'b01) begin
            n_fail++;
            $display("FAIL flush_full: got ready=%b valid=%b, required 0 1", in_ready_a, out_valid_a);
        end
        d0 = dec_a; i0 = ill_a; p0 = popped_a;
        flush_a = 1'b1;
        @(posedge clk); #1;
        flush_a = 1'b0;
        n_checks++;
        if ({out_valid_a, in_ready_a} !== 2'b01) begin
            n_fail++;
            $display("FAIL flush_clear: got valid=%b ready=%b, required 0 1", out_valid_a, in_ready_a);
        end
        out_ready_a = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({dec_a, ill_a} !== {d0, i0} || popped_a !== p0) begin
            n_fail++;
            $display("FAIL flush_counters: got dec=%0d ill=%0d popped=%0d, required %0d %0d %0d",
                     dec_a, ill_a, popped_a, d0, i0, p0);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] tbl [6];
        tbl[0] = 32'hFFF0_0093; tbl[1] = 32'h0000_0000; tbl[2] = 32'h0020_81B3;
        tbl[3] = 32'h0011_2223; tbl[4] = 32'h1234_5037; tbl[5] = 32'h0000_007F;
        out_ready_a = 1'b1;
        for (int k = 0; k < 20; k++) push_a(tbl[k % 6], 32'h1000 + 32'(k * 4));
        @(posedge clk); #1;
        n_checks++;
        if (dec_a !== 4'd15) begin
            n_fail++;
            $display("FAIL sat_dec: got %0d, required 15", dec_a);
        end
        n_checks++;
        if ({28'd0, ill_a} !== exp_ill_a || {28'd0, dec_a} !== exp_dec_a) begin
            n_fail++;
            $display("FAIL sat_model: got dec=%0d ill=%0d, required %0d %0d", dec_a, ill_a, exp_dec_a, exp_ill_a);
        end
        n_checks++;
        if ({dec_b, ill_b} !== {16'(exp_dec_b), 16'(exp_ill_b)}) begin
            n_fail++;
            $display("FAIL cnt_b: got dec=%0d ill=%0d, required %0d %0d", dec_b, ill_b, exp_dec_b, exp_ill_b);
        end
    endtask

    task automatic test_reset_midstream();
        int p0;
        out_ready_a = 1'b0;
        push_a(32'h0010_0093, 32'h500);
        push_a(32'h0020_0113, 32'h504);
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid_a, in_ready_a, dec_a, ill_a} !== 10'd0) begin
            n_fail++;
            $display("FAIL midrst_ctrl: got %b, required 0", {out_valid_a, in_ready_a, dec_a, ill_a});
        end
        n_checks++;
        if ({out_pc_a, out_opcode_a, out_rd_a, out_rs1_a, out_rs2_a, out_funct3_a, out_funct7_a,
             out_imm_a, out_fmt_a, out_illegal_a} !== '0) begin
            n_fail++;
            $display("FAIL midrst_data: got pc=%h imm=%h fmt=%b rd=%0d, required 0", out_pc_a, out_imm_a, out_fmt_a, out_rd_a);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({in_ready_a, in_ready_b} !== 2'b00) begin
            n_fail++;
            $display("FAIL midrst_hold_ready: got %b, required 00", {in_ready_a, in_ready_b});
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready_a !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_release: got in_ready=%b, required 1", in_ready_a);
        end
        p0 = popped_a;
        out_ready_a = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (popped_a !== p0 || out_valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_dropped: got %0d bundles valid=%b, required 0 0", popped_a - p0, out_valid_a);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        flush_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b0; in_instr_a = '0; in_pc_a = '0;
        flush_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b0; in_instr_b = '0; in_pc_b = '0;
        stream_done = 1'b0;
        test_reset();
        test_illegal();
        test_decode32();
        test_decode64();
        test_back_to_back_skid();
        test_back_to_back_noskid();
        test_flush();
        test_saturation();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
